// File: rtl/dead_time_gen.sv
// Dead-time generator: turns a single PWM stream into non-overlapping high/low gate commands.
// Optional fault latch is enabled by defining DEAD_TIME_FAULT_EN.
module dead_time_gen #(
    parameter int DW       = 8,
    parameter int MIN_DEAD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          pwm_in,
    input  logic [DW-1:0] dead,
`ifdef DEAD_TIME_FAULT_EN
    input  logic          fault,
    output logic          fault_latched,
`endif
    output logic          hi_out,
    output logic          lo_out,
    output logic          dead_active
);

    // state | meaning
    // OFF   | disabled, both outputs low, counter cleared
    // DEAD  | dead interval running, both outputs low, dead_active high
    // HI    | high-side command on
    // LO    | low-side command on
    // FAULT | latched fault, both outputs low (fault build only)
    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_DEAD  = 3'd1;
    localparam logic [2:0] ST_HI    = 3'd2;
    localparam logic [2:0] ST_LO    = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [DW-1:0] MIN_DEAD_W = DW'(MIN_DEAD);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          hi_q, hi_d;
    logic          lo_q, lo_d;
    logic          dead_active_q, dead_active_d;
    logic [DW-1:0] eff_dead;
    logic          cnt_tc;
    logic          fault_now;

    assign eff_dead = (dead < MIN_DEAD_W) ? MIN_DEAD_W : dead;
    assign cnt_tc   = (cnt_q == DW'(1));

`ifdef DEAD_TIME_FAULT_EN
    logic fault_latched_q, fault_latched_d;
    assign fault_now = fault;
`else
    assign fault_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_OFF: begin
                state_d = ST_DEAD;
                cnt_d   = eff_dead;
            end
            ST_DEAD: begin
                // Target side is whatever pwm_in says on the last dead cycle.
                if (cnt_tc) begin
                    state_d = pwm_in ? ST_HI : ST_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            ST_HI: begin
                if (!pwm_in) begin
                    state_d = ST_DEAD;
                    cnt_d   = eff_dead;
                end
            end
            ST_LO: begin
                if (pwm_in) begin
                    state_d = ST_DEAD;
                    cnt_d   = eff_dead;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Dropping ena also releases FAULT, provided fault itself is low.
        if (!ena) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end

        if (fault_now) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
        end
    end

    always_comb begin
        hi_d          = (state_d == ST_HI);
        lo_d          = (state_d == ST_LO);
        dead_active_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            hi_q          <= 1'b0;
            lo_q          <= 1'b0;
            dead_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            dead_active_q <= dead_active_d;
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign dead_active = dead_active_q;

`ifdef DEAD_TIME_FAULT_EN
    always_comb begin
        fault_latched_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_latched_q <= 1'b0;
        end else begin
            fault_latched_q <= fault_latched_d;
        end
    end

    assign fault_latched = fault_latched_q;
`endif

endmodule

// File: tb/tb_dead_time_gen.sv
// Bench for dead_time_gen: directed scenarios plus random soak against a behavioural model.
// Fault scenarios are exercised when DEAD_TIME_FAULT_EN is defined.
module tb_dead_time_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] dead = 8'd0;
    logic       fault = 1'b0;
    logic       hi_out, lo_out, dead_active;
`ifdef DEAD_TIME_FAULT_EN
    logic       fault_latched;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: running flag, side, remaining dead cycles, fault latch.
    bit m_run  = 0;
    bit m_side = 0;
    bit m_flt  = 0;
    int m_left = 0;

    always #5 clk = ~clk;

    dead_time_gen #(.DW(8), .MIN_DEAD(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .pwm_in      (pwm_in),
        .dead        (dead),
`ifdef DEAD_TIME_FAULT_EN
        .fault       (fault),
        .fault_latched(fault_latched),
`endif
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .dead_active (dead_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int eff_of(input logic [7:0] d);
        return (int'(d) < 2) ? 2 : int'(d);
    endfunction

    task automatic model_update();
        if (rst) begin
            m_run = 0; m_left = 0; m_flt = 0;
        end else if (fault) begin
            m_flt = 1; m_run = 0; m_left = 0;
        end else if (m_flt) begin
            if (!ena) m_flt = 0;
        end else if (!ena) begin
            m_run = 0; m_left = 0;
        end else if (!m_run) begin
            m_run = 1; m_left = eff_of(dead);
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_side = pwm_in;
        end else if (pwm_in != m_side) begin
            m_left = eff_of(dead);
        end
    endtask

    task automatic step();
        bit e_hi, e_lo, e_da;
        @(posedge clk);
        model_update();
        #1;
        e_hi = m_run && m_left == 0 && m_side;
        e_lo = m_run && m_left == 0 && !m_side;
        e_da = m_run && m_left > 0;
        chk("hi_out", 32'(hi_out), 32'(e_hi));
        chk("lo_out", 32'(lo_out), 32'(e_lo));
        chk("dead_active", 32'(dead_active), 32'(e_da));
        chk("no_overlap", 32'(hi_out & lo_out), 32'd0);
`ifdef DEAD_TIME_FAULT_EN
        chk("fault_latched", 32'(fault_latched), 32'(m_flt));
`endif
    endtask

    // Steps until an output turns on, counting dead_active cycles on the way.
    task automatic run_to_on(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (hi_out || lo_out) return;
            if (dead_active) n++;
        end
        chk("turn_on_timeout", 32'd1, 32'd0);
    endtask

    int  n;
    bit  lo_seen;

    initial begin
        // Reset state
        rst = 1; ena = 0;
        step(); step();
        chk("reset_outs", {29'd0, hi_out, lo_out, dead_active}, 32'd0);
        rst = 0;
        step();

        // 1: first turn-on after reset gets a full dead interval
        ena = 1; dead = 8'd4; pwm_in = 1;
        run_to_on(n);
        chk("t1_dead_cycles", 32'(n), 32'd4);
        chk("t1_hi", 32'(hi_out), 32'd1);
        repeat (5) step();
        chk("t1_hi_steady", 32'(hi_out), 32'd1);

        // 2: HI -> LO commutation
        pwm_in = 0;
        step();
        chk("t2_hi_off", 32'(hi_out), 32'd0);
        chk("t2_dead_now", 32'(dead_active), 32'd1);
        run_to_on(n);
        chk("t2_dead_cycles", 32'(n + 1), 32'd4);
        chk("t2_lo", 32'(lo_out), 32'd1);

        // 3: dead below floor is raised to MIN_DEAD
        dead = 8'd0;
        for (int k = 0; k < 6; k++) begin
            pwm_in = ~pwm_in;
            run_to_on(n);
            chk("t3_min_dead", 32'(n), 32'd2);
            chk("t3_side", 32'(hi_out), 32'(pwm_in));
            repeat (10 - n - 1) step();
        end

        // 4: short low pulse absorbed during dead interval
        pwm_in = 1; dead = 8'd5;
        run_to_on(n);
        repeat (3) step();
        pwm_in = 0;
        step();
        pwm_in = 1;
        lo_seen = lo_out;
        n = 1;
        for (int i = 0; i < 20 && !hi_out; i++) begin
            step();
            lo_seen |= lo_out;
            if (dead_active) n++;
        end
        chk("t4_dead_cycles", 32'(n), 32'd5);
        chk("t4_lo_never", 32'(lo_seen), 32'd0);
        chk("t4_back_hi", 32'(hi_out), 32'd1);

        // 5: ena dropped mid-interval, then full interval on re-enable
        dead = 8'd6; pwm_in = 0;
        step();
        ena = 0;
        step();
        chk("t5_off", {29'd0, hi_out, lo_out, dead_active}, 32'd0);
        step();
        ena = 1;
        run_to_on(n);
        chk("t5_redead", 32'(n), 32'd6);
        chk("t5_lo", 32'(lo_out), 32'd1);

        // dead change mid-interval is ignored
        dead = 8'd3; pwm_in = 1;
        step();
        dead = 8'd9;
        run_to_on(n);
        chk("dead_latched", 32'(n + 1), 32'd3);

        // rst during DEAD forces outputs low regardless of ena
        pwm_in = 0; dead = 8'd8;
        step(); step();
        rst = 1;
        step();
        chk("rst_in_dead", {29'd0, hi_out, lo_out, dead_active}, 32'd0);
        rst = 0;
        run_to_on(n);
        chk("rst_redead", 32'(n), 32'd8);

`ifdef DEAD_TIME_FAULT_EN
        // 6: fault pulse during LO latches until ena=0 with fault=0
        chk("t6_pre_lo", 32'(lo_out), 32'd1);
        fault = 1;
        step();
        fault = 0;
        chk("t6_lo_off", 32'(lo_out), 32'd0);
        chk("t6_latched", 32'(fault_latched), 32'd1);
        repeat (4) step();
        chk("t6_held", 32'(fault_latched), 32'd1);
        ena = 0;
        step();
        chk("t6_cleared", 32'(fault_latched), 32'd0);
        ena = 1;
        run_to_on(n);
        chk("t6_redead", 32'(n), 32'd8);
`endif

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(15) == 0) dead = 8'($urandom_range(12));
            ena = ($urandom_range(40) != 0);
            rst = ($urandom_range(300) == 0);
`ifdef DEAD_TIME_FAULT_EN
            fault = ($urandom_range(200) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
